// File: rtl/updown_sweep_pkg.sv
// Shared types and default sizes for the up/down sweep controller.
package updown_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } sweep_state_t;

  localparam int DEF_W  = 3;
  localparam int DEF_RW = 4;

endpackage

// File: rtl/updown_cnt_core.sv
// Loadable up/down counter register; load has priority over a count step.
module updown_cnt_core
  import updown_sweep_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en) begin
      r_cnt <= up ? (r_cnt + W'(1)) : (r_cnt - W'(1));
    end
  end

  assign count = r_cnt;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep controller: counts lo..hi (optionally back down, repeated reps times),
// then pulses done for one cycle. Limits and reps are captured on start.
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int RW = DEF_RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  input  logic          pingpong,
  input  logic [RW-1:0] reps,
  input  logic          pause,
  output logic [W-1:0]  count,
  output logic          dir,
  output logic          busy,
  output logic          done,
  output logic          err
);

  sweep_state_t  r_state;
  sweep_state_t  w_next;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_hi;
  logic          r_pp;
  logic [RW-1:0] r_reps;
  logic          r_err;

  logic          w_accept;
  logic          w_at_hi;
  logic          w_at_lo;
  logic          w_more_reps;
  logic          w_cnt_en;
  logic          w_cnt_up;
  logic          w_cnt_load;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_at_hi     = (count == r_hi);
  assign w_at_lo     = (count == r_lo);
  assign w_more_reps = (r_reps > RW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Remaining-reps counter and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reps <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_reps <= (reps == '0) ? RW'(1) : reps;
      r_err  <= (lo > hi);
    end else if ((r_state == DOWN) && !pause && w_at_lo) begin
      r_reps <= r_reps - RW'(1);
    end
  end

  // Sweep limits are pure data: captured on accept, never reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lo <= lo;
      r_hi <= hi;
      r_pp <= pingpong;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = (lo > hi) ? DONE : UP;
      end
      UP: begin
        if (!pause && w_at_hi) w_next = (!r_pp || (r_lo == r_hi)) ? DONE : DOWN;
      end
      DOWN: begin
        if (!pause && w_at_lo) w_next = w_more_reps ? UP : DONE;
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs and counter controls
  always_comb begin
    w_cnt_en   = 1'b0;
    w_cnt_up   = 1'b1;
    w_cnt_load = 1'b0;
    busy       = (r_state == UP) || (r_state == DOWN);
    dir        = (r_state != DOWN);
    done       = (r_state == DONE);
    err        = (r_state == DONE) && r_err;
    unique case (r_state)
      IDLE: w_cnt_load = start;
      UP: begin
        if (!pause) begin
          if (!w_at_hi) begin
            w_cnt_en = 1'b1;
          end else if (r_pp && (r_lo != r_hi)) begin
            w_cnt_en = 1'b1;
            w_cnt_up = 1'b0;
          end
        end
      end
      DOWN: begin
        if (!pause) begin
          if (!w_at_lo) begin
            w_cnt_en = 1'b1;
            w_cnt_up = 1'b0;
          end else if (w_more_reps) begin
            w_cnt_en = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  updown_cnt_core #(.W(W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (w_cnt_en),
    .up       (w_cnt_up),
    .load     (w_cnt_load),
    .load_val (lo),
    .count    (count)
  );

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: expected sweeps are built as value lists from
// lo/hi/pingpong/reps and replayed cycle by cycle, honouring pauses.
module tb_updown_sweep_ctrl;

  localparam int W  = 3;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  lo;
  logic [W-1:0]  hi;
  logic          pingpong;
  logic [RW-1:0] reps;
  logic          pause;
  logic [W-1:0]  count;
  logic          dir;
  logic          busy;
  logic          done;
  logic          err;

  int n_assert = 0;
  int n_fail   = 0;

  int exp_cnt[$];
  int exp_dir[$];

  always #5 clk = ~clk;

  updown_sweep_ctrl #(.W(W), .RW(RW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .lo       (lo),
    .hi       (hi),
    .pingpong (pingpong),
    .reps     (reps),
    .pause    (pause),
    .count    (count),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input int c, input int d, input int b,
                         input int dn, input int e);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".dir"},   32'(dir),   32'(d));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".done"},  32'(done),  32'(dn));
    chk({tag, ".err"},   32'(err),   32'(e));
  endtask

  // Expected visible (count, dir) for every busy cycle of a sweep
  task automatic build(input int l, input int h, input int pp, input int rp);
    int r;
    exp_cnt.delete();
    exp_dir.delete();
    r = (rp == 0) ? 1 : rp;
    for (int v = l; v <= h; v++) begin exp_cnt.push_back(v); exp_dir.push_back(1); end
    if (pp != 0 && l != h) begin
      for (int k = 1; k <= r; k++) begin
        for (int v = h - 1; v >= l; v--) begin exp_cnt.push_back(v); exp_dir.push_back(0); end
        if (k < r)
          for (int v = l + 1; v <= h; v++) begin exp_cnt.push_back(v); exp_dir.push_back(1); end
      end
    end
  endtask

  // pmode: 0 no pause, 1 random pauses, 2 three-cycle pause at count 3
  task automatic run_sweep(input int l, input int h, input int pp, input int rp, input int pmode);
    int i, held, guard, last, np;
    bit p;
    @(negedge clk);
    chk("idle.busy", 32'(busy), 0);
    chk("idle.done", 32'(done), 0);
    start = 1'b1; lo = W'(l); hi = W'(h); pingpong = pp[0]; reps = RW'(rp);
    pause = ($urandom_range(0, 1) == 1);
    @(posedge clk);
    if (l > h) begin
      @(negedge clk);
      start = ($urandom_range(0, 1) == 1); pause = ($urandom_range(0, 1) == 1);
      chk_out("err_done", l, 1, 0, 1, 1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; pause = 1'b0;
      chk_out("err_idle", l, 1, 0, 0, 0);
      return;
    end
    build(l, h, pp, rp);
    i = 0; held = 0; guard = 0; np = 0;
    while (i < exp_cnt.size() && guard < 300) begin
      @(negedge clk);
      chk_out("sweep", exp_cnt[i], exp_dir[i], 1, 0, 0);
      if (pmode == 1) p = ($urandom_range(0, 3) == 0);
      else if (pmode == 2) p = (exp_cnt[i] == 3) && (held < 3);
      else p = 1'b0;
      if (p && pmode == 2) held++;
      if (p) np++;
      pause = p;
      start = ($urandom_range(0, 1) == 1);
      lo = W'($urandom_range(0, 7)); hi = W'($urandom_range(0, 7));
      pingpong = ($urandom_range(0, 1) == 1); reps = RW'($urandom_range(0, 15));
      @(posedge clk);
      if (!p) i++;
      guard++;
    end
    if (pmode == 2) chk("pause_cycles", 32'(np), 3);
    last = exp_cnt[exp_cnt.size() - 1];
    @(negedge clk);
    chk_out("done", last, 1, 0, 1, 0);
    start = ($urandom_range(0, 1) == 1); pause = ($urandom_range(0, 1) == 1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; pause = 1'b0;
    chk_out("post_idle", last, 1, 0, 0, 0);
  endtask

  initial begin
    bit reached;
    reset = 1'b1; start = 1'b0; lo = '0; hi = '0; pingpong = 1'b0; reps = '0; pause = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 0, 1, 0, 0, 0);
    reset = 1'b0;

    run_sweep(2, 5, 0, 0, 0);   // basic single sweep
    run_sweep(1, 3, 1, 2, 0);   // two ping-pong cycles
    run_sweep(6, 2, 0, 0, 0);   // lo > hi
    run_sweep(4, 4, 1, 3, 0);   // degenerate range
    run_sweep(2, 5, 0, 0, 2);   // pause at count 3
    run_sweep(0, 7, 1, 1, 1);   // full range with pauses

    // Reset mid-DOWN while paused and with start held
    @(negedge clk);
    start = 1'b1; lo = 3'd1; hi = 3'd6; pingpong = 1'b1; reps = 4'd1;
    @(posedge clk);
    reached = 1'b0;
    for (int k = 0; k < 40 && !reached; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (count == 3'd4 && dir == 1'b0) reached = 1'b1;
      else @(posedge clk);
    end
    chk("rst_reach", 32'(reached), 1);
    reset = 1'b1; start = 1'b1; pause = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_out("rst_mid", 0, 1, 0, 0, 0);
    reset = 1'b0; start = 1'b0; pause = 1'b0;
    run_sweep(2, 5, 0, 0, 0);

    for (int t = 0; t < 20; t++)
      run_sweep($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 3), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 Parameter W, default 3: counter width in bits.
REQ-002 Parameter RW, default 4: repetition-count width in bits.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: sweep request; sampled only in IDLE.
REQ-006 Port lo, input, W: lower sweep limit; latched on an accepted start.
REQ-007 Port hi, input, W: upper sweep limit; latched on an accepted start.
REQ-008 Port pingpong, input, 1: latched on an accepted start; 0 selects a single up sweep; 1 selects up-then-down sweeps.
REQ-009 Port reps, input, RW: number of ping-pong cycles; latched on an accepted start; 0 treated as 1.
REQ-010 Port pause, input, 1: freezes count and state while high in UP/DOWN.
REQ-011 Port count, output, W: current counter value.
REQ-012 Port dir, output, 1: 1 = counting up, 0 = counting down.
REQ-013 Port busy, output, 1: high in UP and DOWN.
REQ-014 Port done, output, 1: one-cycle completion pulse.
REQ-015 Port err, output, 1: high together with done when latched lo > hi.

Function
REQ-016 The states SHALL be IDLE, UP, DOWN and DONE.
REQ-017 In IDLE, start=1 SHALL latch lo, hi, pingpong and reps (0 becomes 1), load count<=lo, and enter UP; if lo>hi it SHALL instead enter DONE with err set.
REQ-018 In UP with pause=0 and count!=hi, count SHALL increment by 1 each cycle.
REQ-019 In UP with count==hi: if pingpong=0 or lo==hi, it SHALL enter DONE with count held; otherwise it SHALL enter DOWN and set count<=count-1 in the same cycle.
REQ-020 In DOWN with pause=0 and count!=lo, count SHALL decrement by 1 each cycle.
REQ-021 In DOWN with count==lo, the remaining-reps counter SHALL decrement; if the value before decrement is >1 it SHALL enter UP with count<=count+1; otherwise it SHALL enter DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1 and then return to IDLE; count SHALL hold its last value through DONE and IDLE.
REQ-023 dir SHALL be 1 in IDLE, UP and DONE, and 0 in DOWN.
REQ-024 pause=1 SHALL hold count, state and the reps counter, and SHALL be ignored in IDLE and DONE.
REQ-025 start outside IDLE SHALL be ignored, including in DONE.
REQ-026 count SHALL never wrap; all values SHALL stay within [lo,hi].
REQ-027 Single-sweep latency from the start cycle to the done cycle SHALL be hi-lo+2 cycles, excluding paused cycles.
REQ-028 err SHALL be 0 except in a DONE cycle entered because lo>hi.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, count=0, the reps counter=0, done=0, err=0, busy=0 and dir=1, overriding every other input, including mid-sweep and while paused.

Structure
REQ-030 Package updown_sweep_pkg SHALL hold typedef sweep_state_t (IDLE, UP, DOWN, DONE) and the default W and RW constants.
REQ-031 Sub-module updown_cnt_core SHALL hold the counter register: inputs en, up, load, load_val; synchronous active-high reset to 0.
REQ-032 The FSM and the latched limit/reps registers SHALL reside in updown_sweep_ctrl.

Verification
REQ-033 Scenario: W=3, lo=2, hi=5, pingpong=0, start at cycle 0 -> count=2,3,4,5 on cycles 1-4; done=1 on cycle 5; IDLE on cycle 6.
REQ-034 Scenario: lo=1, hi=3, pingpong=1, reps=2 -> count sequence 1,2,3,2,1,2,3,2,1, then a single done pulse; dir=0 exactly on the down steps.
REQ-035 Scenario: lo=6, hi=2, start -> done=1 and err=1 on the next cycle; count=6; busy never asserted.
REQ-036 Scenario: lo=hi=4 with pingpong=1 -> count=4 for one UP cycle, then done; no DOWN state entered.
REQ-037 Scenario: pause held for 3 cycles at count=3 during the REQ-033 sweep -> count stays 3; done is delayed by exactly 3 cycles.
REQ-038 Scenario: reset asserted at count=4 in DOWN, with start held high -> next cycle IDLE, count=0; the start after reset release begins a fresh sweep.
